// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command-line parser: ASCII codes, FSM encodings, field widths.
package uart_cmd_pkg;

    localparam int LOC_W = 12;
    localparam int DIS_W = 13;
    localparam int ACC_W = 14;

    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_D     = 8'h44;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLON   = 3'd1;
    localparam logic [2:0] ST_NUM1    = 3'd2;
    localparam logic [2:0] ST_NUM2    = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal field accumulator: acc = acc*10 + digit, with digit-count and range lookahead.
module dec_accum
    import uart_cmd_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    input  logic [ACC_W-1:0] limit,
    output logic [ACC_W-1:0] value,
    output logic             ovf,
    output logic             empty
);
    localparam int DW = $clog2(MAX_DIGITS + 1);

    logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
    logic [DW-1:0]    digits_q, digits_d;

    always_comb begin
        acc_nxt  = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, digit};
        acc_d    = acc_q;
        digits_d = digits_q;
        if (clr) begin
            acc_d    = '0;
            digits_d = '0;
        end else if (digit_en) begin
            acc_d    = acc_nxt;
            digits_d = digits_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            digits_q <= '0;
        end else begin
            acc_q    <= acc_d;
            digits_q <= digits_d;
        end
    end

    // ovf describes the digit currently presented, so the parent can reject it before accepting
    assign ovf   = (digits_q == DW'(MAX_DIGITS)) || (acc_nxt > limit);
    assign value = acc_q;
    assign empty = (digits_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "L:<x>,<y>" and "D:<d>" ASCII lines from uart_rx into one-cycle command strobes.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int TIMEOUT_US = 1000,
    parameter int MAX_DIGITS = 4,
    parameter int LOC_MAX    = 4095,
    parameter int DIS_MAX    = 8191
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             rx_data_ready,
    output logic [LOC_W-1:0] cmd_loc_x,
    output logic [LOC_W-1:0] cmd_loc_y,
    output logic             cmd_loc_valid,
    output logic [DIS_W-1:0] cmd_dis,
    output logic             cmd_dis_valid,
    output logic             cmd_err,
    output logic [7:0]       err_cnt
);
    localparam int TO_CYC = CLK_FRE * TIMEOUT_US;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic             op_loc_q, op_loc_d;
    logic [LOC_W-1:0] x_tmp_q, x_tmp_d;
    logic [LOC_W-1:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;
    logic [DIS_W-1:0] dis_q, dis_d;
    logic             loc_vld_q, loc_vld_d, dis_vld_q, dis_vld_d;
    logic             err_q, err_d, rdy_q, rdy_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;

    logic             acc_clr, acc_en, acc_ovf, acc_empty;
    logic [ACC_W-1:0] acc_val, acc_limit;
    logic             byte_ok, is_dig, is_trm, expire, fail, fld_ok;

    dec_accum #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .digit_en (acc_en),
        .digit    (rx_data[3:0]),
        .limit    (acc_limit),
        .value    (acc_val),
        .ovf      (acc_ovf),
        .empty    (acc_empty)
    );

    assign byte_ok   = rx_data_valid && rdy_q;
    assign is_dig    = is_digit(rx_data);
    assign is_trm    = is_term(rx_data);
    assign acc_limit = op_loc_q ? ACC_W'(LOC_MAX) : ACC_W'(DIS_MAX);
    // the high-bit test never trips after a range-checked digit; it just keeps truncation honest
    assign fld_ok    = !acc_empty && (acc_val[ACC_W-1:DIS_W] == '0);
    assign expire    = (state_q != ST_IDLE) && !byte_ok && (tmo_q == TO_W'(TO_CYC - 1));

    always_comb begin
        state_d   = state_q;
        op_loc_d  = op_loc_q;
        x_tmp_d   = x_tmp_q;
        loc_x_d   = loc_x_q;
        loc_y_d   = loc_y_q;
        dis_d     = dis_q;
        loc_vld_d = 1'b0;
        dis_vld_d = 1'b0;
        fail      = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        if (byte_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == CH_L || rx_data == CH_D) begin
                        op_loc_d = (rx_data == CH_L);
                        state_d  = ST_COLON;
                    end else if (!is_trm) begin
                        fail = 1'b1;
                    end
                end
                ST_COLON: begin
                    if (rx_data == CH_COLON) begin
                        acc_clr = 1'b1;
                        state_d = ST_NUM1;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_NUM1, ST_NUM2: begin
                    if (is_dig) begin
                        if (acc_ovf) fail = 1'b1;
                        else         acc_en = 1'b1;
                    end else if (rx_data == CH_COMMA && state_q == ST_NUM1 && op_loc_q) begin
                        if (fld_ok) begin
                            x_tmp_d = acc_val[LOC_W-1:0];
                            acc_clr = 1'b1;
                            state_d = ST_NUM2;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (is_trm && (state_q == ST_NUM2 || !op_loc_q)) begin
                        if (!fld_ok) begin
                            fail = 1'b1;
                        end else if (op_loc_q) begin
                            loc_x_d   = x_tmp_q;
                            loc_y_d   = acc_val[LOC_W-1:0];
                            loc_vld_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            dis_d     = acc_val[DIS_W-1:0];
                            dis_vld_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (is_trm) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            // a bad terminator already ends the line, so there is nothing left to discard
            if (fail) state_d = is_trm ? ST_IDLE : ST_DISCARD;
        end else if (expire) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        err_d     = fail || (expire && state_q != ST_DISCARD);
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        tmo_d     = (state_q == ST_IDLE || byte_ok) ? '0 : tmo_q + TO_W'(1);
        rdy_d     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_loc_q  <= 1'b0;
            x_tmp_q   <= '0;
            loc_x_q   <= '0;
            loc_y_q   <= '0;
            dis_q     <= '0;
            loc_vld_q <= 1'b0;
            dis_vld_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            tmo_q     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_loc_q  <= op_loc_d;
            x_tmp_q   <= x_tmp_d;
            loc_x_q   <= loc_x_d;
            loc_y_q   <= loc_y_d;
            dis_q     <= dis_d;
            loc_vld_q <= loc_vld_d;
            dis_vld_q <= dis_vld_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            tmo_q     <= tmo_d;
            rdy_q     <= rdy_d;
        end
    end

    assign rx_data_ready = rdy_q;
    assign cmd_loc_x     = loc_x_q;
    assign cmd_loc_y     = loc_y_q;
    assign cmd_loc_valid = loc_vld_q;
    assign cmd_dis       = dis_q;
    assign cmd_dis_valid = dis_vld_q;
    assign cmd_err       = err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench: a line-level reference model predicts strobes; a negedge monitor checks them.
module tb_uart_cmd_parser;
    localparam int CLK_FRE = 1, TIMEOUT_US = 40, TO = CLK_FRE * TIMEOUT_US;
    localparam int MAXD = 4, LOC_MAX = 4095, DIS_MAX = 8191;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        rx_data_ready, cmd_loc_valid, cmd_dis_valid, cmd_err;
    logic [11:0] cmd_loc_x, cmd_loc_y;
    logic [12:0] cmd_dis;
    logic [7:0]  err_cnt;

    uart_cmd_parser #(.CLK_FRE(CLK_FRE), .TIMEOUT_US(TIMEOUT_US), .MAX_DIGITS(MAXD),
                      .LOC_MAX(LOC_MAX), .DIS_MAX(DIS_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .cmd_loc_x(cmd_loc_x), .cmd_loc_y(cmd_loc_y),
        .cmd_loc_valid(cmd_loc_valid), .cmd_dis(cmd_dis), .cmd_dis_valid(cmd_dis_valid),
        .cmd_err(cmd_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int x; int y; int d; int ecnt; } exp_t; // kind 0=loc 1=dis 2=err
    exp_t expq[$];
    int n_chk = 0, n_fail = 0;

    // reference model state
    bit         in_line, bad;
    logic [7:0] lbuf[$];
    int         idle_cnt, mx, my, md, mecnt;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit is_t(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    // 0: not a prefix of any legal line, 1: legal prefix, 2: complete legal line
    function automatic int eval_line(input logic [7:0] q[$], output int f0, output int f1);
        int nf, dig, val, lim;
        nf = 0; dig = 0; val = 0; f0 = 0; f1 = 0;
        if (q.size() >= 1 && q[0] != "L" && q[0] != "D") return 0;
        if (q.size() >= 2 && q[1] != ":") return 0;
        lim = (q[0] == "L") ? LOC_MAX : DIS_MAX;
        for (int i = 2; i < q.size(); i++) begin
            if (q[i] >= "0" && q[i] <= "9") begin
                dig++;
                val = val * 10 + (int'(q[i]) - 48);
                if (dig > MAXD || val > lim) return 0;
            end else if (q[i] == "," && q[0] == "L" && nf == 0 && dig > 0) begin
                f0 = val; nf = 1; dig = 0; val = 0;
            end else begin
                return 0;
            end
        end
        if (nf == 0) f0 = val; else f1 = val;
        if (dig > 0 && ((q[0] == "D") ? (nf == 0) : (nf == 1))) return 2;
        return 1;
    endfunction

    function automatic void push_ev(input int kind);
        exp_t e;
        e.kind = kind; e.x = mx; e.y = my; e.d = md; e.ecnt = mecnt;
        expq.push_back(e);
    endfunction

    function automatic void model_err();
        if (mecnt < 255) mecnt++;
        push_ev(2);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int f0, f1, r;
        if (!in_line) begin
            if (!is_t(b)) begin
                in_line = 1; bad = 0; lbuf = {b};
                if (eval_line(lbuf, f0, f1) == 0) begin bad = 1; model_err(); end
            end
        end else if (bad) begin
            if (is_t(b)) in_line = 0;
        end else if (is_t(b)) begin
            in_line = 0;
            r = eval_line(lbuf, f0, f1);
            if (r == 2) begin
                if (lbuf[0] == "L") begin mx = f0; my = f1; push_ev(0); end
                else begin md = f0; push_ev(1); end
            end else begin
                model_err();
            end
        end else begin
            lbuf.push_back(b);
            if (eval_line(lbuf, f0, f1) == 0) begin bad = 1; model_err(); end
        end
    endfunction

    task automatic tick_idle();
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
        idle_cnt++;
        if (in_line && idle_cnt == TO) begin
            if (!bad) model_err();
            in_line = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data_valid = 1'b1;
        rx_data = b;
        model_byte(b);
        idle_cnt = 0;
    endtask

    task automatic send_str(input string s, input bit rnd);
        int g;
        for (int i = 0; i < s.len(); i++) begin
            g = 0;
            if (rnd) g = ($urandom_range(0, 40) == 0) ? TO - 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
            repeat (g) tick_idle();
            send_byte(s[i]);
        end
        tick_idle();
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_ready", rx_data_ready, 0);
        chk("rst_loc_x", cmd_loc_x, 0);
        chk("rst_loc_y", cmd_loc_y, 0);
        chk("rst_dis", cmd_dis, 0);
        chk("rst_strobes", {cmd_loc_valid, cmd_dis_valid, cmd_err}, 0);
        chk("rst_err_cnt", err_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rx_data_valid = 1'b0;
        in_line = 0; bad = 0; mx = 0; my = 0; md = 0; mecnt = 0; idle_cnt = 0;
        repeat (3) @(posedge clk);
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick_idle();
        @(negedge clk);
        chk("ready_after_reset", rx_data_ready, 1);
    endtask

    task automatic send_rand_line();
        string s, pool, tm;
        int t, n;
        pool = "LD:,0123456789X";
        t = $urandom_range(0, 9);
        case (t)
            0, 1, 2, 3: s = $sformatf("L:%0d,%0d", $urandom_range(0, 4300), $urandom_range(0, 4300));
            4, 5:       s = $sformatf("D:%0d", $urandom_range(0, 8400));
            6: begin
                s = "";
                n = $urandom_range(1, 8);
                for (int i = 0; i < n; i++) s = {s, string'(pool[$urandom_range(0, pool.len() - 1)])};
            end
            7:          s = "";
            8:          s = $sformatf("L:%04d,%0d", $urandom_range(0, 4200), $urandom_range(0, 99));
            default:    s = $sformatf("D:%0d", $urandom_range(10000, 99999));
        endcase
        case ($urandom_range(0, 2))
            0:       tm = "\r";
            1:       tm = "\n";
            default: tm = "\r\n";
        endcase
        send_str({s, tm}, 1'b1);
    endtask

    // monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst_n && (cmd_loc_valid || cmd_dis_valid || cmd_err)) begin
            kind = cmd_err ? 2 : (cmd_dis_valid ? 1 : 0);
            chk("strobe_onehot", int'(cmd_loc_valid) + int'(cmd_dis_valid) + int'(cmd_err), 1);
            if (expq.size() == 0) begin
                chk("unexpected_strobe_kind", kind, -1);
            end else begin
                e = expq.pop_front();
                chk("kind", kind, e.kind);
                chk("loc_x", cmd_loc_x, e.x);
                chk("loc_y", cmd_loc_y, e.y);
                chk("dis", cmd_dis, e.d);
                chk("err_cnt", err_cnt, e.ecnt);
            end
        end
    end

    initial begin
        in_line = 0; bad = 0; idle_cnt = 0; mx = 0; my = 0; md = 0; mecnt = 0;
        repeat (3) @(posedge clk);
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick_idle();
        @(negedge clk);
        chk("ready_after_reset", rx_data_ready, 1);

        // directed lines
        send_str("L:123,45\r\n", 1'b0);
        send_str("D:8191\n", 1'b0);
        send_str("D:8192\n", 1'b0);
        send_str("L:12\r", 1'b0);
        send_str("X:1\r", 1'b0);
        send_str("L:,5\r", 1'b0);
        send_str("D:12345\r", 1'b0);
        send_str("L:4095,0\n", 1'b0);
        send_str("L:4096,1\n", 1'b0);
        repeat (4) tick_idle();
        @(negedge clk);
        chk("held_dis_after_reject", cmd_dis, 8191);

        // timeout mid-line, then recovery
        send_byte("L"); send_byte(":"); send_byte("7");
        repeat (TO + 5) tick_idle();
        send_str("L:1,2\r", 1'b0);
        // byte in the expiry cycle wins
        send_byte("L"); send_byte(":"); send_byte("5");
        repeat (TO - 1) tick_idle();
        send_str(",6\r", 1'b0);
        // expiry out of DISCARD is silent
        send_byte("X");
        repeat (TO + 3) tick_idle();
        send_str("D:0\r", 1'b0);

        for (int i = 0; i < 150; i++) send_rand_line();
        repeat (TO + 5) tick_idle();

        // reset mid-line
        send_byte("L"); send_byte(":"); send_byte("9"); send_byte("9"); send_byte(",");
        @(negedge clk);
        chk("queue_drained_before_reset", expq.size(), 0);
        expq.delete();
        do_reset();
        send_str("9\r", 1'b0);

        // err_cnt saturation
        for (int i = 0; i < 300; i++) send_str("X\r", 1'b0);
        repeat (4) tick_idle();
        @(negedge clk);
        chk("err_cnt_saturated", err_cnt, 255);

        repeat (TO + 10) tick_idle();
        @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
